sipo_frame_rx_controller: RTL

- Sequences an 8-bit serial-in-parallel-out shift datapath to receive fixed-length frames of FRAME_BYTES bytes.
- Counts qualified serial bits and assembles each byte LSB-first.
- Hands each completed byte to a downstream consumer through a single-entry valid/ready output buffer.
- Flags overrun when the consumer stalls, and signals frame completion.

---
 rtl/sipo_frame_rx_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sipo_frame_rx_controller.sv
// -----------------------------------------------------------------------------
// sipo_frame_rx_controller
//
// Receives fixed-length frames of FRAME_BYTES bytes from a qualified serial
// bit stream. Bits are assembled LSB-first into bytes. Each completed byte is
// handed to a downstream consumer through a single-entry valid/ready buffer.
//
// Handshake (valid/ready): a byte transfers on every rising edge where
// Byte_Valid_Out=1 and Byte_Ready_In=1. While Byte_Valid_Out=1 and
// Byte_Ready_In=0, Byte_Data_Out and Byte_Last_Out hold steady. Byte_Ready_In
// has no effect while Byte_Valid_Out=0.
//
// Ports:
//   Clk_In          clock, rising edge
//   Reset_In        asynchronous, active-high reset
//   Serial_Data_In  serial bit, sampled when Bit_Valid_In=1 in SHIFT
//   Bit_Valid_In    qualifies Serial_Data_In
//   Frame_Start_In  pulse: start, or restart, a frame
//   Byte_Ready_In   consumer accepts Byte_Data_Out
//   Byte_Data_Out   completed byte, first received bit at bit 0
//   Byte_Valid_Out  output buffer holds an unconsumed byte
//   Byte_Last_Out   output byte is the last byte of its frame
//   Frame_Done_Out  one-cycle pulse, final byte of the frame assembled
//   Overrun_Out     sticky, a completed byte was dropped
//   Busy_Out        FSM is in SHIFT
//   Bit_Count_Out   bits collected in the current byte
// -----------------------------------------------------------------------------
module sipo_frame_rx_controller #(
  parameter int FRAME_BYTES = 4
) (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic       Serial_Data_In,
  input  logic       Bit_Valid_In,
  input  logic       Frame_Start_In,
  input  logic       Byte_Ready_In,
  output logic [7:0] Byte_Data_Out,
  output logic       Byte_Valid_Out,
  output logic       Byte_Last_Out,
  output logic       Frame_Done_Out,
  output logic       Overrun_Out,
  output logic       Busy_Out,
  output logic [2:0] Bit_Count_Out
);

  localparam int BC_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_BYTES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;

  logic [7:0]      shifted;
  logic            is_last_byte;
  logic            buf_free;

  // New bit enters at the top and walks toward bit 0, so after eight shifts
  // the first bit received sits at bit 0.
  assign shifted      = {Serial_Data_In, sr_q[7:1]};
  assign is_last_byte = (byte_cnt_q == LAST_IDX);
  // A buffer being drained this very cycle can be refilled without a bubble.
  assign buf_free     = !out_valid_q || Byte_Ready_In;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q     <= ST_IDLE;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;

    // The output buffer drains regardless of FSM state.
    if (out_valid_q && Byte_Ready_In) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (Frame_Start_In) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          overrun_d  = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (Frame_Start_In) begin
          // Restart: drop the partial byte, keep any byte already buffered.
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          overrun_d  = 1'b0;
        end else if (Bit_Valid_In) begin
          sr_d      = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = is_last_byte ? '0 : byte_cnt_q + BC_W'(1);
            if (buf_free) begin
              out_data_d  = shifted;
              out_valid_d = 1'b1;
              out_last_d  = is_last_byte;
            end else begin
              overrun_d = 1'b1;
            end
            if (is_last_byte) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign Byte_Data_Out  = out_data_q;
  assign Byte_Valid_Out = out_valid_q;
  assign Byte_Last_Out  = out_last_q;
  assign Frame_Done_Out = done_q;
  assign Overrun_Out    = overrun_q;
  assign Busy_Out       = (state_q == ST_SHIFT);
  assign Bit_Count_Out  = bit_cnt_q;

endmodule
